// File: rtl/flop_delay_line.sv
// flop_delay_line: flop-based retiming delay line for LANES x WIDTH data plus a
// valid bit. The delay can be changed at runtime from 1 to MAX_DEPTH cycles.
// A change of delay discards the valid bits in flight. busy then stays high
// until the first sample accepted after the change reaches the output.
// Optional feature macro: DLY_OCC_CNT_EN adds the occ port. occ is a
// popcount of the valid bits currently inside the active part of the line.
module flop_delay_line #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 2,
  parameter int MAX_DEPTH = 16,
  parameter int RESET_DLY = 4,
  localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
  input  logic                     CP,
  input  logic                     CDN,
  inout  wire                      VDD,
  inout  wire                      VSS,
  input  logic [LANES*WIDTH-1:0]   din,
  input  logic                     din_vld,
  input  logic [DEPTH_W-1:0]       dly_sel,
  input  logic                     dly_load,
  output logic [LANES*WIDTH-1:0]   dout,
  output logic                     dout_vld,
  output logic                     busy
`ifdef DLY_OCC_CNT_EN
  ,
  output logic [DEPTH_W-1:0]       occ
`endif
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t                   state, state_nxt;
  logic [DEPTH_W-1:0]       cur_dly, cur_dly_nxt;
  logic [DEPTH_W-1:0]       cnt, cnt_nxt;
  logic [DEPTH_W-1:0]       new_dly;
  logic [DEPTH_W-1:0]       tap;
  logic                     flush;

  logic [MAX_DEPTH-1:0]     stage_vld;
  logic [LANES*WIDTH-1:0]   stage_data [MAX_DEPTH];

  // A requested delay of 0 becomes 1.
  // A request above MAX_DEPTH becomes MAX_DEPTH.
  function automatic logic [DEPTH_W-1:0] clamp_dly(input logic [DEPTH_W-1:0] sel);
    if (sel == '0)
      return DEPTH_W'(1);
    else if (sel > DEPTH_W'(MAX_DEPTH))
      return DEPTH_W'(MAX_DEPTH);
    else
      return sel;
  endfunction

  // Control state: FSM state, active delay and drain counter
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state   <= RUN;
      cur_dly <= DEPTH_W'(RESET_DLY);
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      cur_dly <= cur_dly_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Next-state logic. A load that keeps the current delay is a no-op.
  // Loads are ignored while a drain is in progress.
  always_comb begin
    state_nxt   = state;
    cur_dly_nxt = cur_dly;
    cnt_nxt     = cnt;
    flush       = 1'b0;
    new_dly     = clamp_dly(dly_sel);
    case (state)
      RUN: begin
        if (dly_load && (new_dly != cur_dly)) begin
          cur_dly_nxt = new_dly;
          cnt_nxt     = new_dly;
          state_nxt   = DRAIN;
          flush       = 1'b1;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt - DEPTH_W'(1);
        if (cnt == DEPTH_W'(1))
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Output logic: busy flag and the output tap mux at stage cur_dly-1
  always_comb begin
    busy     = (state == DRAIN);
    tap      = cur_dly - DEPTH_W'(1);
    dout     = '0;
    dout_vld = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (DEPTH_W'(i) == tap) begin
        dout     = stage_data[i];
        dout_vld = stage_vld[i];
      end
    end
  end

  // Shift register. On a reload edge, every valid bit is cleared, including
  // the sample taken at that edge. Data bits keep shifting.
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      stage_vld <= '0;
      for (int i = 0; i < MAX_DEPTH; i++)
        stage_data[i] <= '0;
    end else begin
      stage_vld     <= flush ? '0 : {stage_vld[MAX_DEPTH-2:0], din_vld};
      stage_data[0] <= din;
      for (int i = 1; i < MAX_DEPTH; i++)
        stage_data[i] <= stage_data[i-1];
    end
  end

`ifdef DLY_OCC_CNT_EN
  // Occupancy: count of valid samples in the observed stages 0..cur_dly-1
  always_comb begin
    occ = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (DEPTH_W'(i) < cur_dly)
        occ = occ + DEPTH_W'(stage_vld[i]);
    end
  end
`endif

endmodule

// File: tb/tb_flop_delay_line.sv
// tb_flop_delay_line: directed bench for flop_delay_line with default parameters
// (WIDTH=8, LANES=2, MAX_DEPTH=16, RESET_DLY=4).
module tb_flop_delay_line;

  logic        CP;
  logic        CDN;
  wire         vdd = 1'b1;
  wire         vss = 1'b0;
  logic [15:0] din;
  logic        din_vld;
  logic [4:0]  dly_sel;
  logic        dly_load;
  logic [15:0] dout;
  logic        dout_vld;
  logic        busy;
`ifdef DLY_OCC_CNT_EN
  logic [4:0]  occ;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;   // index of the next active edge

  flop_delay_line dut (
    .CP       (CP),
    .CDN      (CDN),
    .VDD      (vdd),
    .VSS      (vss),
    .din      (din),
    .din_vld  (din_vld),
    .dly_sel  (dly_sel),
    .dly_load (dly_load),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy)
`ifdef DLY_OCC_CNT_EN
    ,
    .occ      (occ)
`endif
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  typedef struct {
    logic [15:0] din;
    logic        vld;
    logic [15:0] exp_dout;
    logic        exp_vld;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [15:0] pat(input int e);
    return 16'(e * 291 + 165);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [15:0] d, input logic v, input logic ld, input logic [4:0] sel);
    din      = d;
    din_vld  = v;
    dly_load = ld;
    dly_sel  = sel;
  endtask

  // One streaming cycle with valid data whose value identifies its edge
  task automatic stream_tick();
    drive(pat(cyc), 1'b1, 1'b0, 5'd0);
    tick();
  endtask

  // Load a delay while streaming; returns the load edge index
  task automatic load_tick(input logic [4:0] sel, output int l_edge);
    l_edge = cyc;
    drive(pat(cyc), 1'b1, 1'b1, sel);
    tick();
  endtask

  // Stream for the drain period and check busy/valid. Then check the
  // latency for a few cycles after busy falls.
  task automatic drain_and_check(input string tag, input int l_edge, input int dly, input int post);
    check({tag, "_busy_at_load"}, 32'(busy), 32'd1);
    check({tag, "_vld_at_load"}, 32'(dout_vld), 32'd0);
    for (int k = 1; k < dly; k++) begin
      stream_tick();
      check({tag, "_busy_drain"}, 32'(busy), 32'd1);
      check({tag, "_vld_drain"}, 32'(dout_vld), 32'd0);
    end
    for (int k = 0; k < post; k++) begin
      stream_tick();
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_vld_after"}, 32'(dout_vld), 32'd1);
      check({tag, "_dout_after"}, 32'(dout), 32'(pat(l_edge + 1 + k)));
    end
  endtask

  initial begin
    int l_edge;
    int e0;

    // Table: single valid sample at edge 0 under the reset delay of 4
    vecs[0] = '{16'hA55A, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 1'b0, 16'hA55A, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    CDN = 1'b0;
    drive(16'h0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_vld", 32'(dout_vld), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
`ifdef DLY_OCC_CNT_EN
    check("reset_occ", 32'(occ), 32'd0);
`endif
    CDN = 1'b1;
    cyc = 0;

    // Latency 4 after reset, without any load
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].din, vecs[i].vld, 1'b0, 5'd0);
      tick();
      check($sformatf("tbl%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      check($sformatf("tbl%0d_vld", i), 32'(dout_vld), 32'(vecs[i].exp_vld));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
    end

    // Fill the line with continuous data, then reload to 9
    for (int k = 0; k < 5; k++) stream_tick();
    check("pre9_vld", 32'(dout_vld), 32'd1);
    check("pre9_dout", 32'(dout), 32'(pat(cyc - 4)));
    load_tick(5'd9, l_edge);
    drain_and_check("dly9", l_edge, 9, 4);

    // dly_sel 0 clamps to delay 1
    load_tick(5'd0, l_edge);
    drain_and_check("dly0to1", l_edge, 1, 3);

    // dly_sel 31 clamps to delay 16
    load_tick(5'd31, l_edge);
    drain_and_check("dly31to16", l_edge, 16, 3);

    // Reload to 4. A second load of 7 during the drain is ignored.
    load_tick(5'd4, l_edge);
    check("ld4_busy", 32'(busy), 32'd1);
    drive(pat(cyc), 1'b1, 1'b1, 5'd7);
    tick();
    check("ign7_busy", 32'(busy), 32'd1);
    check("ign7_vld", 32'(dout_vld), 32'd0);
    stream_tick();
    stream_tick();
    check("ign7_busy_last", 32'(busy), 32'd1);
    stream_tick();
    check("ign7_busy_fall", 32'(busy), 32'd0);
    check("ign7_vld_rise", 32'(dout_vld), 32'd1);
    check("ign7_dout", 32'(dout), 32'(pat(l_edge + 1)));
    stream_tick();
    check("ign7_lat4", 32'(dout), 32'(pat(cyc - 4)));

    // A load equal to the current delay does not interrupt the data
    drive(pat(cyc), 1'b1, 1'b1, 5'd4);
    tick();
    check("same4_busy", 32'(busy), 32'd0);
    check("same4_vld", 32'(dout_vld), 32'd1);
    check("same4_dout", 32'(dout), 32'(pat(cyc - 4)));
    for (int k = 0; k < 3; k++) begin
      stream_tick();
      check("same4_cont_busy", 32'(busy), 32'd0);
      check("same4_cont_vld", 32'(dout_vld), 32'd1);
      check("same4_cont_dout", 32'(dout), 32'(pat(cyc - 4)));
    end

    // Asynchronous reset three cycles into a drain of 12
    load_tick(5'd12, l_edge);
    stream_tick();
    stream_tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    CDN = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_vld", 32'(dout_vld), 32'd0);
    check("async_rst_dout", 32'(dout), 32'd0);
    drive(16'h0, 1'b0, 1'b0, 5'd0);
    tick();
    CDN = 1'b1;
    e0 = cyc;
    drive(16'h5A5A, 1'b1, 1'b0, 5'd0);
    tick();
    drive(16'h0, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_vld", 32'(dout_vld), (cyc - 1 == e0 + 3) ? 32'd1 : 32'd0);
      check("post_rst_dout", 32'(dout), (cyc - 1 == e0 + 3) ? 32'h5A5A : 32'd0);
    end

`ifdef DLY_OCC_CNT_EN
    // Occupancy with alternating valid: delay 8 gives 4
    load_tick(5'd8, l_edge);
    check("occ_after_load8", 32'(occ), 32'd0);
    for (int k = 0; k < 16; k++) begin
      drive(pat(cyc), (cyc % 2) == 0, 1'b0, 5'd0);
      tick();
    end
    check("occ_dly8", 32'(occ), 32'd4);
    load_tick(5'd3, l_edge);
    check("occ_after_load3", 32'(occ), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(pat(cyc), (cyc % 2) == 0, 1'b0, 5'd0);
      tick();
      check("occ_le2", 32'(occ <= 5'd2), 32'd1);
      if (k >= 2)
        check("occ_dly3", 32'(occ), ((cyc - 1) % 2 == 0) ? 32'd2 : 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
